// File: rtl/player_action_engine.sv
// Player action engine: turns conditioned input pulses into player column, aim and a single projectile.
// Latency: every state change is registered one ena-qualified clock after the inputs that cause it.
// Backpressure: none; ena=0 freezes all state and forces shot_done low.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ena                   global enable
//   left_x/right_x        move pulses, valid when select[4]
//   left_aim/right_aim    aim pulses, valid when select[3]
//   shoot_out             fire pulse, accepted only in READY
//   select[4:0]           [4] move, [3] aim, [2] new game held, [1] new game released, [0] unused
//   player_x, aim         player column and aim index (2 = straight up)
//   shot_active/x/y       projectile state
//   shot_done             one-cycle pulse when a flight ends
//   busy                  high in every state except READY
module player_action_engine #(
   parameter int X_W        = 4,
   parameter int X_MAX      = 15,
   parameter int Y_W        = 4,
   parameter int Y_MAX      = 15,
   parameter int STEP_TICKS = 8,
   parameter int COOL_TICKS = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ena,
   input  logic           left_x,
   input  logic           right_x,
   input  logic           left_aim,
   input  logic           right_aim,
   input  logic           shoot_out,
   input  logic [4:0]     select,
   output logic [X_W-1:0] player_x,
   output logic [2:0]     aim,
   output logic           shot_active,
   output logic [X_W-1:0] shot_x,
   output logic [Y_W-1:0] shot_y,
   output logic           shot_done,
   output logic           busy
);

   localparam int SC_W = $clog2(STEP_TICKS + 1);
   localparam int CC_W = $clog2(COOL_TICKS + 1);
   localparam logic [X_W-1:0] X_C      = X_W'(X_MAX / 2);
   localparam logic [X_W-1:0] X_MAX_V  = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);
   localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_TICKS - 1);
   localparam logic [CC_W-1:0] COOL_LAST = CC_W'(COOL_TICKS - 1);
   // Two extra bits so column + (dir-2) can go below 0 or above X_MAX without wrapping.
   localparam logic signed [X_W+1:0] NX_MAX = (X_W+2)'(X_MAX);
   localparam logic signed [X_W+1:0] NX_TWO = (X_W+2)'(2);

   typedef enum logic [1:0] {
      S_READY   = 2'd0,
      S_FLIGHT  = 2'd1,
      S_COOL    = 2'd2,
      S_NEWGAME = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [X_W-1:0]  player_x_q, player_x_d;
   logic [2:0]      aim_q, aim_d;
   logic [2:0]      dir_q, dir_d;
   logic            shot_active_q, shot_active_d;
   logic [X_W-1:0]  shot_x_q, shot_x_d;
   logic [Y_W-1:0]  shot_y_q, shot_y_d;
   logic            shot_done_q, shot_done_d;
   logic [SC_W-1:0] step_cnt_q, step_cnt_d;
   logic [CC_W-1:0] cool_cnt_q, cool_cnt_d;

   logic                  move_l, move_r, aim_l, aim_r;
   logic signed [X_W+1:0] nx;
   logic                  nx_oob;
   logic [Y_W-1:0]        new_y;
   logic                  end_flight;

   // Simultaneous left+right pulses cancel out.
   assign move_l = select[4] & left_x    & ~right_x;
   assign move_r = select[4] & right_x   & ~left_x;
   assign aim_l  = select[3] & left_aim  & ~right_aim;
   assign aim_r  = select[3] & right_aim & ~left_aim;

   assign nx     = $signed({2'b00, shot_x_q}) + $signed({{(X_W-1){1'b0}}, dir_q}) - NX_TWO;
   assign nx_oob = nx[X_W+1] || (nx > NX_MAX);
   assign new_y  = shot_y_q + Y_W'(1);

   always_comb begin
      state_d       = state_q;
      player_x_d    = player_x_q;
      aim_d         = aim_q;
      dir_d         = dir_q;
      shot_active_d = shot_active_q;
      shot_x_d      = shot_x_q;
      shot_y_d      = shot_y_q;
      shot_done_d   = 1'b0;
      step_cnt_d    = step_cnt_q;
      cool_cnt_d    = cool_cnt_q;
      end_flight    = 1'b0;

      if (ena) begin
         if (select[2]) begin
            // New game overrides everything, in every state.
            state_d       = S_NEWGAME;
            player_x_d    = X_C;
            aim_d         = 3'd2;
            shot_active_d = 1'b0;
            shot_x_d      = '0;
            shot_y_d      = '0;
            step_cnt_d    = '0;
            cool_cnt_d    = '0;
         end else if (state_q == S_NEWGAME) begin
            if (select[1]) begin
               state_d = S_READY;
            end
         end else begin
            if (move_l && player_x_q != '0)      player_x_d = player_x_q - X_W'(1);
            if (move_r && player_x_q != X_MAX_V) player_x_d = player_x_q + X_W'(1);
            if (aim_l && aim_q != 3'd0)          aim_d = aim_q - 3'd1;
            if (aim_r && aim_q != 3'd4)          aim_d = aim_q + 3'd1;

            case (state_q)
               S_READY: begin
                  if (shoot_out) begin
                     // Launch uses the pre-move column and pre-change aim.
                     shot_x_d      = player_x_q;
                     shot_y_d      = '0;
                     dir_d         = aim_q;
                     shot_active_d = 1'b1;
                     step_cnt_d    = '0;
                     state_d       = S_FLIGHT;
                  end
               end
               S_FLIGHT: begin
                  if (step_cnt_q == STEP_LAST) begin
                     step_cnt_d = '0;
                     if (nx_oob) begin
                        // Leaving the playfield sideways: last position stays visible.
                        end_flight = 1'b1;
                     end else begin
                        shot_x_d = nx[X_W-1:0];
                        shot_y_d = new_y;
                        if (new_y == Y_MAX_V) end_flight = 1'b1;
                     end
                  end else begin
                     step_cnt_d = step_cnt_q + SC_W'(1);
                  end
               end
               S_COOL: begin
                  if (cool_cnt_q == COOL_LAST) begin
                     state_d = S_READY;
                  end else begin
                     cool_cnt_d = cool_cnt_q + CC_W'(1);
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase

            if (end_flight) begin
               shot_active_d = 1'b0;
               shot_done_d   = 1'b1;
               cool_cnt_d    = '0;
               state_d       = S_COOL;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_READY;
         player_x_q    <= X_C;
         aim_q         <= 3'd2;
         dir_q         <= 3'd2;
         shot_active_q <= 1'b0;
         shot_x_q      <= '0;
         shot_y_q      <= '0;
         shot_done_q   <= 1'b0;
         step_cnt_q    <= '0;
         cool_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         player_x_q    <= player_x_d;
         aim_q         <= aim_d;
         dir_q         <= dir_d;
         shot_active_q <= shot_active_d;
         shot_x_q      <= shot_x_d;
         shot_y_q      <= shot_y_d;
         shot_done_q   <= shot_done_d;
         step_cnt_q    <= step_cnt_d;
         cool_cnt_q    <= cool_cnt_d;
      end
   end

   assign player_x    = player_x_q;
   assign aim         = aim_q;
   assign shot_active = shot_active_q;
   assign shot_x      = shot_x_q;
   assign shot_y      = shot_y_q;
   assign shot_done   = shot_done_q;
   assign busy        = (state_q != S_READY);

endmodule
